// File: rtl/scope_pkg.sv
// Shared scope types: ADC sample format, frame length and the trace store state encoding.
package scope_pkg;

    localparam int ADC_W   = 12;
    localparam int ADC_MID = 2048;
    localparam int SAMPLES = 256;

    typedef logic [ADC_W-1:0] adc_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        PENDING
    } trace_state_e;

endpackage

// File: rtl/trace_frame_store_if.sv
// Bundle between the trigger stage / draw stage (master) and the trace frame store (slave).
interface trace_frame_store_if #(
    parameter int Y_W = 10
);
    import scope_pkg::*;

    adc_sample_t             trigger_buffer [scope_pkg::SAMPLES];
    logic                    read;
    logic                    frame_start;
    logic [2:0]              volt_shift;
    logic signed [10:0]      y_offset;
    logic [7:0]              pix_x;
    logic [Y_W-1:0]          trace_y;
    logic                    trace_valid;
    logic                    busy;
    logic                    frame_swapped;
    logic [7:0]              dropped_frames;

    modport master (
        output trigger_buffer, read, frame_start, volt_shift, y_offset, pix_x,
        input  trace_y, trace_valid, busy, frame_swapped, dropped_frames
    );

    modport slave (
        input  trigger_buffer, read, frame_start, volt_shift, y_offset, pix_x,
        output trace_y, trace_valid, busy, frame_swapped, dropped_frames
    );

endinterface

// File: rtl/trace_bank_ram.sv
// Two-bank simple dual-port trace RAM; the bank is the address MSB, read data is registered.
module trace_bank_ram #(
    parameter int Y_W = 10,
    parameter int AW  = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [Y_W-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [Y_W-1:0] rdata
);

    logic [Y_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents are left as they are.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_frame_store.sv
// Double-buffered trace store: copies a captured frame into the back bank and swaps on vertical blanking.
// Optional TRACE_DROP_COUNT_EN builds a saturating counter of frames ignored while busy.
module trace_frame_store #(
    parameter int SAMPLES  = 256,
    parameter int Y_W      = 10,
    parameter int Y_CENTER = 300,
    parameter int Y_MIN    = 44,
    parameter int Y_MAX    = 555
) (
    input  logic              clk,
    input  logic              rst,
    trace_frame_store_if.slave bus
);
    import scope_pkg::*;

    localparam int                 IDX_W      = $clog2(SAMPLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(SAMPLES - 1);
    localparam logic signed [13:0] Y_CENTER_S = 14'(Y_CENTER);
    localparam logic signed [13:0] Y_MIN_S    = 14'(Y_MIN);
    localparam logic signed [13:0] Y_MAX_S    = 14'(Y_MAX);

    trace_state_e     state;
    logic [IDX_W-1:0] idx;
    logic             front_sel;
    logic             read_d;
    logic             new_frame;
    logic             busy_r;
    logic             trace_valid_r;
    logic             frame_swapped_r;
    logic [Y_W-1:0]   wr_y;

    function automatic logic [Y_W-1:0] scale(
        input adc_sample_t        code,
        input logic [2:0]         shift,
        input logic signed [10:0] offset
    );
        logic signed [12:0] d;
        logic signed [12:0] d_s;
        logic signed [13:0] y;
        d   = $signed({1'b0, code}) - $signed(13'(ADC_MID));
        d_s = d >>> shift;
        y   = Y_CENTER_S + {{3{offset[10]}}, offset} - {d_s[12], d_s};
        if (y < Y_MIN_S) begin
            scale = Y_W'(Y_MIN_S);
        end else if (y > Y_MAX_S) begin
            scale = Y_W'(Y_MAX_S);
        end else begin
            scale = Y_W'(y);
        end
    endfunction

    assign new_frame = bus.read & ~read_d;

    always_comb begin
        wr_y = scale(bus.trigger_buffer[idx], bus.volt_shift, bus.y_offset);
    end

    // Frame copy / swap sequencer; read_d resets high so a level already up at reset is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            idx             <= '0;
            front_sel       <= 1'b0;
            read_d          <= 1'b1;
            busy_r          <= 1'b0;
            trace_valid_r   <= 1'b0;
            frame_swapped_r <= 1'b0;
        end else begin
            read_d          <= bus.read;
            frame_swapped_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame) begin
                        idx    <= '0;
                        state  <= COPY;
                        busy_r <= 1'b1;
                    end
                end
                COPY: begin
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (bus.frame_start) begin
                        front_sel       <= ~front_sel;
                        frame_swapped_r <= 1'b1;
                        trace_valid_r   <= 1'b1;
                        busy_r          <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    trace_bank_ram #(
        .Y_W (Y_W),
        .AW  (IDX_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (state == COPY),
        .waddr ({~front_sel, idx}),
        .wdata (wr_y),
        .raddr ({front_sel, bus.pix_x[IDX_W-1:0]}),
        .rdata (bus.trace_y)
    );

    assign bus.busy          = busy_r;
    assign bus.trace_valid   = trace_valid_r;
    assign bus.frame_swapped = frame_swapped_r;

`ifdef TRACE_DROP_COUNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (new_frame && (state != IDLE) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.dropped_frames = drop_cnt;
`else
    assign bus.dropped_frames = '0;
`endif

endmodule

// File: tb/tb_trace_frame_store.sv
// Directed bench for trace_frame_store: table of frame/readback vectors plus multi-cycle corner sequences.
module tb_trace_frame_store;
    import scope_pkg::*;

    localparam int Y_W = 10;

    typedef struct {
        int fillKind;
        int fillVal;
        int vs;
        int off;
        int pix;
        int expY;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecCount = 0;
    int   missCount = 0;
    int   expDrop = 0;
    vec_t vecs [12];

    always #5 clk = ~clk;

    trace_frame_store_if #(.Y_W(Y_W)) bus ();

    trace_frame_store #(
        .SAMPLES  (256),
        .Y_W      (Y_W),
        .Y_CENTER (300),
        .Y_MIN    (44),
        .Y_MAX    (555)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int dropModel();
`ifdef TRACE_DROP_COUNT_EN
        return expDrop;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int fillKind, input int fillVal, input int vs, input int off);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            bus.trigger_buffer[i] = (fillKind == 1) ? 12'(16 * i) : 12'(fillVal);
        end
        bus.volt_shift = 3'(vs);
        bus.y_offset   = 11'(off);
    endtask

    // Rising edge on read, then 256 copy cycles; optional frame_start pulses mid-copy and on the last write.
    task automatic runCopy(input bit noisyStart);
        @(negedge clk);
        bus.read        = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge clk);
        bus.read = 1'b1;
        @(posedge clk);
        #1 checkOutput("busy_after_edge", bus.busy, 1);
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            bus.frame_start = noisyStart && (c == 10 || c == 256);
            @(posedge clk);
        end
        #1;
        checkOutput("busy_pending", bus.busy, 1);
        checkOutput("no_early_swap", bus.frame_swapped, 0);
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic swapFrame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("swap_pulse", bus.frame_swapped, 1);
        checkOutput("swap_valid", bus.trace_valid, 1);
        checkOutput("swap_idle", bus.busy, 0);
        @(negedge clk);
        bus.frame_start = 1'b0;
        @(posedge clk);
        #1 checkOutput("swap_pulse_end", bus.frame_swapped, 0);
    endtask

    task automatic readY(input string name, input int pix, input int expected);
        @(negedge clk);
        bus.pix_x = 8'(pix);
        @(posedge clk);
        #1 checkOutput(name, bus.trace_y, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 2048, 0, 0,    0,   300};
        vecs[1]  = '{0, 2048, 0, 0,    255, 300};
        vecs[2]  = '{0, 2048, 0, 0,    77,  300};
        vecs[3]  = '{1, 0,    3, 0,    0,   555};
        vecs[4]  = '{1, 0,    3, 0,    128, 300};
        vecs[5]  = '{1, 0,    3, 0,    255, 46};
        vecs[6]  = '{1, 0,    3, 0,    64,  428};
        vecs[7]  = '{0, 4095, 0, -400, 10,  44};
        vecs[8]  = '{0, 0,    0, -400, 10,  555};
        vecs[9]  = '{0, 3000, 2, 25,   200, 87};
        vecs[10] = '{0, 1000, 7, -10,  33,  299};
        vecs[11] = '{0, 2049, 0, 0,    5,   299};

        bus.read        = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_x       = 8'd0;
        bus.volt_shift  = 3'd0;
        bus.y_offset    = 11'sd0;
        for (int i = 0; i < 256; i++) begin
            bus.trigger_buffer[i] = 12'd0;
        end
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_trace_y", bus.trace_y, 0);
        checkOutput("reset_valid", bus.trace_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_swapped", bus.frame_swapped, 0);
        checkOutput("reset_dropped", bus.dropped_frames, 0);

        // read is already high as reset releases: no frame must start
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkOutput("no_edge_after_reset", bus.busy, 0);

        for (int i = 0; i < 12; i++) begin
            if (i == 0 || vecs[i].fillKind != vecs[i-1].fillKind || vecs[i].fillVal != vecs[i-1].fillVal ||
                vecs[i].vs != vecs[i-1].vs || vecs[i].off != vecs[i-1].off) begin
                applyStimulus(vecs[i].fillKind, vecs[i].fillVal, vecs[i].vs, vecs[i].off);
                runCopy(1'b0);
                swapFrame();
            end
            readY($sformatf("vec%0d_trace_y", i), vecs[i].pix, vecs[i].expY);
        end

        // Read latency: a new pix_x just after the edge must not alter trace_y until the next edge
        applyStimulus(1, 0, 3, 0);
        runCopy(1'b0);
        swapFrame();
        @(negedge clk);
        bus.pix_x = 8'd0;
        @(posedge clk);
        #1 bus.pix_x = 8'd255;
        #1 checkOutput("latency_hold", bus.trace_y, 555);
        @(posedge clk);
        #1 checkOutput("latency_next", bus.trace_y, 46);

        // frame_start during COPY and on the final write is ignored; old trace stays visible
        applyStimulus(0, 2048, 0, 0);
        runCopy(1'b1);
        readY("old_trace_held", 128, 300 - 0);
        readY("old_trace_held_edge", 0, 555);
        swapFrame();
        readY("new_after_swap", 0, 300);

        // Edges while PENDING are dropped and counted (saturating)
        applyStimulus(0, 2048, 4, 0);
        runCopy(1'b0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            bus.read = 1'b0;
            @(negedge clk);
            bus.read = 1'b1;
            if (expDrop < 255) begin
                expDrop++;
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                checkOutput("drop_one", bus.dropped_frames, dropModel());
            end
        end
        checkOutput("drop_saturate", bus.dropped_frames, dropModel());
        checkOutput("drop_still_pending", bus.busy, 1);
        swapFrame();
        readY("after_drops", 3, 300);

        // Reset in the middle of a copy
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        bus.read = 1'b0;
        @(negedge clk);
        bus.read = 1'b1;
        @(posedge clk);
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midcopy_busy", bus.busy, 0);
        checkOutput("midcopy_valid", bus.trace_valid, 0);
        checkOutput("midcopy_trace_y", bus.trace_y, 0);
        checkOutput("midcopy_dropped", bus.dropped_frames, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkOutput("midcopy_no_restart", bus.busy, 0);
        applyStimulus(0, 1500, 2, 0);
        runCopy(1'b0);
        swapFrame();
        readY("post_reset_pix0", 0, 437);
        readY("post_reset_pix100", 100, 437);
        readY("post_reset_pix255", 255, 437);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
